// File: rtl/spi_cmd_sequencer.sv
// Command sequencer in front of the SPI master: buffers byte / chip-select
// commands, issues them one at a time on load/in, waits out SPI busy and
// returns every received byte with a one-cycle valid strobe.
module spi_cmd_sequencer #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [8:0]             wr_data,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf,
    output logic                   busy,
    output logic                   spi_load,
    output logic [15:0]            spi_in,
    input  logic [15:0]            spi_out,
    output logic [7:0]             rx_data,
    output logic                   rx_valid
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWait,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [8:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q;
    logic [8:0]     cmd_q;
    logic           ovf_q;
    logic [7:0]     rx_data_q;
    logic           push, pop, rx_capture;

    // spi_out[14:8] carries nothing this block needs.
    logic unused_spi_out;
    assign unused_spi_out = ^spi_out[14:8];

    // full is derived from the registered count, so a same-cycle pop never frees a slot.
    assign full = (count_q == FullCount);
    assign push = wr_en && !full;
    assign pop  = (state_q == StIdle) && (count_q != '0);

    // FIFO storage; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // FIFO pointers, occupancy, sticky overflow and the popped command register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            cmd_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                cmd_q    <= mem[rd_ptr_q];
            end
            if (wr_en && full) begin
                ovf_q <= 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // State register and captured receive byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rx_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (rx_capture) begin
                rx_data_q <= spi_out[7:0];
            end
        end
    end

    // Next-state logic: a CS release needs no transfer, so it returns straight to idle.
    always_comb begin
        state_d    = state_q;
        rx_capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                state_d = cmd_q[8] ? StIdle : StWait;
            end
            StWait: begin
                if (!spi_out[15]) begin
                    state_d    = StDone;
                    rx_capture = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Strobes come straight from the registered state, so each lasts exactly one cycle.
    assign spi_load = (state_q == StLoad);
    assign rx_valid = (state_q == StDone);
    assign spi_in   = {7'd0, cmd_q};
    assign rx_data  = rx_data_q;
    assign count    = count_q;
    assign ovf      = ovf_q;
    assign busy     = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer: a behavioural SPI master stand-in, a queue and
// timeline based reference model compared every cycle, plus directed literal checks.
module tb_spi_cmd_sequencer;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [8:0]  wr_data = '0;
    logic        full;
    logic [3:0]  count;
    logic        ovf, busy, spi_load, rx_valid;
    logic [15:0] spi_in, spi_out;
    logic [7:0]  rx_data;

    always #5 clk = ~clk;

    spi_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .count    (count),
        .ovf      (ovf),
        .busy     (busy),
        .spi_load (spi_load),
        .spi_in   (spi_in),
        .spi_out  (spi_out),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_load = 0;
    int n_rxv = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // SPI master stand-in: 16 busy cycles per byte, 8 MSB-first shifts, SDI from a table.
    logic       s_busy = 1'b0;
    logic       csx = 1'b1;
    logic [3:0] s_cnt = '0;
    logic [7:0] shreg = '0, sdo_rec = '0, cur_sdi = '0;
    int         s_idx = 0;
    logic [7:0] sdi_tab [64];
    logic       sdi;

    assign sdi     = cur_sdi[3'd7 - s_cnt[3:1]];
    assign spi_out = {s_busy, 7'd0, shreg};

    always @(posedge clk) begin
        if (spi_load && !spi_in[8]) begin
            s_busy  <= 1'b1;
            s_cnt   <= '0;
            shreg   <= spi_in[7:0];
            csx     <= 1'b0;
            cur_sdi <= sdi_tab[s_idx];
            s_idx   <= s_idx + 1;
        end else if (spi_load) begin
            csx <= 1'b1;
        end else if (s_busy) begin
            s_cnt <= s_cnt + 1'b1;
            if (s_cnt[0]) begin
                shreg   <= {shreg[6:0], sdi};
                sdo_rec <= {sdo_rec[6:0], shreg[7]};
            end
            if (s_cnt == 4'd15) begin
                s_busy <= 1'b0;
            end
        end
    end

    // Reference model: command queue plus a job timeline (t=1 load, t=19 valid for bytes).
    logic [8:0] mq[$];
    bit         m_act = 1'b0;
    int         m_t = 0;
    logic [8:0] m_cmd = '0;
    logic [7:0] m_rx = '0;
    bit         m_ovf = 1'b0;
    int         m_idx = 0;
    int         m_job = 0;
    bit         m_was_full;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_act = 1'b0;
            m_t   = 0;
            m_cmd = '0;
            m_rx  = '0;
            m_ovf = 1'b0;
        end else begin
            m_was_full = (mq.size() == DEPTH);
            if (m_act) begin
                m_t++;
                if (!m_cmd[8] && m_t == 19) m_rx = sdi_tab[m_job];
                if ((m_cmd[8] && m_t == 2) || m_t == 20) m_act = 1'b0;
            end else if (mq.size() != 0) begin
                m_cmd = mq.pop_front();
                m_act = 1'b1;
                m_t   = 1;
                if (!m_cmd[8]) begin
                    m_job = m_idx;
                    m_idx++;
                end
            end
            if (wr_en) begin
                if (m_was_full) m_ovf = 1'b1;
                else mq.push_back(wr_data);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        chk("count", count, mq.size());
        chk("full", full, mq.size() == DEPTH);
        chk("ovf", ovf, m_ovf);
        chk("busy", busy, m_act || mq.size() != 0);
        chk("spi_load", spi_load, m_act && m_t == 1);
        chk("spi_in", spi_in, {7'd0, m_cmd});
        chk("rx_valid", rx_valid, m_act && !m_cmd[8] && m_t == 19);
        chk("rx_data", rx_data, m_rx);
        if (m_act && !m_cmd[8] && m_t == 19) chk("sdo_byte", sdo_rec, m_cmd[7:0]);
        if (spi_load) n_load++;
        if (rx_valid) n_rxv++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [8:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        cyc(1);
        wr_en   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    int l0, r0;

    initial begin
        for (int i = 0; i < 64; i++) sdi_tab[i] = 8'($urandom);
        sdi_tab[0] = 8'hFF;

        // Reset values
        #2;
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_load", spi_load, 0);
        chk("rst_spi_in", spi_in, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // Single byte, SDI all ones
        push(9'h0A5);
        chk("t1_count_c1", count, 1);
        cyc(1);
        chk("t1_load_c2", spi_load, 1);
        chk("t1_spi_in_c2", spi_in, 16'h00A5);
        cyc(1);
        chk("t1_csx_c3", csx, 0);
        cyc(17);
        chk("t1_rx_valid_c20", rx_valid, 1);
        chk("t1_rx_data_c20", rx_data, 8'hFF);
        cyc(1);
        chk("t1_busy_c21", busy, 0);
        cyc(3);

        // Byte, CS release, CS release
        l0 = n_load;
        r0 = n_rxv;
        push(9'h0A5);
        push(9'h13C);
        push(9'h100);
        cyc(45);
        chk("t2_loads", n_load - l0, 3);
        chk("t2_rx_pulses", n_rxv - r0, 1);
        chk("t2_busy", busy, 0);
        chk("t2_csx_high", csx, 1);
        chk("t2_spi_in", spi_in, 16'h0100);

        // Fill the FIFO behind a running transfer, then overflow
        r0 = n_rxv;
        push(9'h0FF);
        for (int i = 1; i <= 8; i++) push(9'(i));
        chk("t3_count_full", count, 8);
        chk("t3_full", full, 1);
        push(9'h0EE);
        chk("t3_ovf", ovf, 1);
        chk("t3_count_after_drop", count, 8);
        cyc(180);
        chk("t3_rx_pulses", n_rxv - r0, 9);
        chk("t3_count_empty", count, 0);
        chk("t3_ovf_sticky", ovf, 1);

        // Reset in cycle 10 of a transfer with three entries queued
        push(9'h011);
        push(9'h022);
        push(9'h033);
        cyc(7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_count", count, 0);
        chk("t5_full", full, 0);
        chk("t5_ovf", ovf, 0);
        chk("t5_busy", busy, 0);
        chk("t5_load", spi_load, 0);
        chk("t5_spi_in", spi_in, 0);
        chk("t5_rx_data", rx_data, 0);
        chk("t5_rx_valid", rx_valid, 0);
        cyc(1);
        #2;
        rst_n = 1'b1;
        l0 = n_load;
        cyc(30);
        chk("t5_no_load", n_load - l0, 0);
        chk("t5_busy_idle", busy, 0);

        // Push during DONE with an empty FIFO
        l0 = n_load;
        r0 = n_rxv;
        push(9'h055);
        cyc(19);
        chk("t6_done_c20", rx_valid, 1);
        chk("t6_empty_c20", count, 0);
        push(9'h066);
        chk("t6_count_c21", count, 1);
        cyc(1);
        chk("t6_load_c22", spi_load, 1);
        chk("t6_spi_in_c22", spi_in, 16'h0066);
        cyc(25);
        chk("t6_loads", n_load - l0, 2);
        chk("t6_rx_pulses", n_rxv - r0, 2);
        chk("t6_busy", busy, 0);

        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
